// File: rtl/route_lock_ctrl_if.sv
// Handshake and status bundle between a route's operator/field inputs
// and its lock controller.
interface route_lock_ctrl_if;
    logic       i_req;
    logic       i_grant;
    logic       i_points_ok;
    logic       i_occupied;
    logic       i_cancel;
    logic       o_locked;
    logic       o_signal;
    logic       o_fault;
    logic [2:0] o_state;

    modport master (
        output i_req, i_grant, i_points_ok, i_occupied, i_cancel,
        input  o_locked, o_signal, o_fault, o_state
    );

    modport slave (
        input  i_req, i_grant, i_points_ok, i_occupied, i_cancel,
        output o_locked, o_signal, o_fault, o_state
    );
endinterface

// File: rtl/route_lock_ctrl.sv
// Per-route lock controller: request/permit to held lock, proceed
// aspect, points-prove timeout and approach-locked timed release.
module route_lock_ctrl #(
    parameter int TIMER_W       = 16,
    parameter int POINT_TIMEOUT = 1000,
    parameter int RELEASE_DELAY = 5000
) (
    input logic              i_clk,
    input logic              i_rst,
    route_lock_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTING   = 3'd1,
        PROCEED   = 3'd2,
        OCCUPIED  = 3'd3,
        RELEASING = 3'd4
    } state_t;

    localparam logic [TIMER_W-1:0] PT_LOAD = TIMER_W'(POINT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] RD_LOAD = TIMER_W'(RELEASE_DELAY - 1);

    state_t             state, nxt_state;
    logic [TIMER_W-1:0] timer, nxt_timer;
    logic               armed, nxt_armed;
    logic               fault, nxt_fault;
    logic               locked, signal;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            timer  <= '0;
            armed  <= 1'b0;
            fault  <= 1'b0;
            locked <= 1'b0;
            signal <= 1'b0;
        end else begin
            state  <= nxt_state;
            timer  <= nxt_timer;
            armed  <= nxt_armed;
            fault  <= nxt_fault;
            locked <= (nxt_state != IDLE);
            signal <= (nxt_state == PROCEED);
        end
    end

    // Timer defaults to 0 so it rests at 0 outside the timed states.
    always_comb begin
        nxt_state = IDLE;
        nxt_timer = '0;
        nxt_fault = 1'b0;
        nxt_armed = armed | ~bus.i_req;
        case (state)
            IDLE: begin
                if (bus.i_req && bus.i_grant && armed) begin
                    nxt_state = SETTING;
                    nxt_timer = PT_LOAD;
                    nxt_armed = 1'b0;
                end
            end
            SETTING: begin
                if (bus.i_cancel) begin
                    nxt_state = IDLE;
                end else if (bus.i_points_ok) begin
                    nxt_state = PROCEED;
                end else if (timer == '0) begin
                    nxt_state = IDLE;
                    nxt_fault = 1'b1;
                end else begin
                    nxt_state = SETTING;
                    nxt_timer = timer - 1'b1;
                end
            end
            PROCEED: begin
                if (bus.i_occupied) begin
                    nxt_state = OCCUPIED;
                end else if (bus.i_cancel || !bus.i_points_ok) begin
                    nxt_state = RELEASING;
                    nxt_timer = RD_LOAD;
                end else begin
                    nxt_state = PROCEED;
                end
            end
            OCCUPIED: begin
                nxt_state = bus.i_occupied ? OCCUPIED : IDLE;
            end
            RELEASING: begin
                if (bus.i_occupied) begin
                    nxt_state = OCCUPIED;
                end else if (timer != '0) begin
                    nxt_state = RELEASING;
                    nxt_timer = timer - 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign bus.o_locked = locked;
    assign bus.o_signal = signal;
    assign bus.o_fault  = fault;
    assign bus.o_state  = state;

endmodule

// File: doc/route_lock_ctrl.md
Name: route_lock_ctrl

Overview:
Per-route sequential lock controller placed directly downstream of a route's combinational interlock permit (the o_<route> output).
- Turns an operator request plus the interlock permit into a held route lock, a proceed aspect and timed release.
- o_locked is the route's "set" indication and feeds the conflict inputs of the other routes' interlocks.
- One instance is used per route.

Parameters:
TIMER_W, 16, width of the shared down-counter.
POINT_TIMEOUT, 1000, cycles allowed in SETTING for points to prove; range 1..2^TIMER_W-1.
RELEASE_DELAY, 5000, approach-locking hold after a cancel from PROCEED; range 1..2^TIMER_W-1.

Ports:
i_clk  in  1  clock; all state changes on the rising edge.
i_rst  in  1  synchronous reset, active-high.
i_req  in  1  operator route request, level.
i_grant  in  1  interlock permit from the upstream combinational stage.
i_points_ok  in  1  points detected in the correct position for this route.
i_occupied  in  1  first track section of the route is occupied.
i_cancel  in  1  operator cancel, level.
o_locked  out  1  route locked; feeds the other routes' interlocks.
o_signal  out  1  proceed aspect (1 = proceed, 0 = stop).
o_fault  out  1  one-cycle pulse on points timeout.
o_state  out  3  state code: IDLE=0, SETTING=1, PROCEED=2, OCCUPIED=3, RELEASING=4.

Behaviour:
- All outputs are registered. Inputs are sampled on the rising edge and the resulting state and outputs are visible in the next cycle.
- Reset, whether at power-up or mid-operation in any state: state=IDLE, o_locked=0, o_signal=0, o_fault=0, timer=0, req_armed=0.
- req_armed is set when i_req is sampled 0 and cleared on request acceptance. A request held high across a return to IDLE therefore never relocks the route; the operator must drop and re-assert i_req.
- IDLE (locked=0, signal=0):
  - If i_req & i_grant & req_armed: go to SETTING and load timer=POINT_TIMEOUT-1.
  - i_grant is sampled only in IDLE.
- SETTING (locked=1, signal=0):
  - i_cancel -> IDLE.
  - Else i_points_ok -> PROCEED.
  - Else if timer==0 -> IDLE with o_fault=1 for one cycle.
  - Else timer decrements.
  - Net effect: timeout exit comes after exactly POINT_TIMEOUT cycles in SETTING. i_points_ok in the final cycle beats the timeout.
- PROCEED (locked=1, signal=1):
  - i_occupied -> OCCUPIED.
  - Else i_cancel -> RELEASING with timer=RELEASE_DELAY-1.
  - i_occupied has priority over i_cancel when both are sampled together.
  - If i_points_ok drops, go to RELEASING with timer loaded; this is a safety drop of the aspect.
- OCCUPIED (locked=1, signal=0):
  - Stay until i_occupied is sampled 0, then -> IDLE (route-release by train passage).
  - i_cancel is ignored in this state.
- RELEASING (locked=1, signal=0):
  - i_occupied -> OCCUPIED; the train entered during approach locking.
  - Else if timer==0 -> IDLE.
  - Else timer decrements.
  - Net effect: IDLE is reached exactly RELEASE_DELAY cycles after entry. i_cancel has no effect in this state.
- o_signal is 1 only in PROCEED. o_locked is 1 in every state except IDLE.
- o_fault is 0 except for the single cycle after a timeout.
- o_state encodes the current state; codes 5..7 are never produced. An illegal state recovers to IDLE with locked=0 on the next edge.
- Timer:
  - Loaded only on entry to SETTING or RELEASING.
  - Never wraps; it holds at 0 outside the timed states.

Test Plan:
(Parameters for all scenarios: POINT_TIMEOUT=4, RELEASE_DELAY=6.)
1. Full route cycle:
   - Stimulus: req=1, grant=1 at cycle 0; points_ok=1 at cycle 2; occupied=1 at cycle 5, 0 at cycle 9.
   - Required: locked=1 from cycle 1; signal=1 for cycles 3..5; state=OCCUPIED from cycle 6; IDLE and locked=0 at cycle 10.
2. Points timeout:
   - Stimulus: req+grant at cycle 0; points_ok held 0.
   - Required: state=SETTING for cycles 1..4; IDLE at cycle 5 with o_fault=1 for cycle 5 only; no relock while req is still 1.
3. Approach locking:
   - Stimulus: reach PROCEED, then cancel=1 for one cycle.
   - Required: signal=0 on the next cycle; locked=1 for exactly 6 cycles in RELEASING; then IDLE.
   - Repeat with occupied=1 at the 3rd RELEASING cycle -> OCCUPIED, locked stays 1.
4. Priority and gating:
   - Stimulus: in PROCEED, occupied=1 and cancel=1 together; separately, req=1 with grant=0.
   - Required: the first goes to OCCUPIED; the second stays in IDLE with locked=0.
5. Reset mid-operation:
   - Stimulus: assert i_rst for one cycle while in PROCEED, and again while in RELEASING with timer=3.
   - Required: the next cycle shows locked=0, signal=0, fault=0, state=0 in both cases.
6. Re-arm:
   - Stimulus: req held at 1 through scenario 1's return to IDLE, then req=0 for 1 cycle, then req=1.
   - Required: no relock while req is held; SETTING entered on the cycle after re-assertion.
